ctrl_sequencer: RTL
===================

# ctrl_sequencer

Multi-cycle control sequencer for the accumulator CPU. It replaces the purely combinational opcode decoder with a registered FETCH/DECODE/EXEC state machine. The sequencer handles memory-ready and I/O handshakes, resolves conditional branches from the C/Z flags, and aborts stalled memory/I/O accesses with a cycle timeout. Opcode width is parametrised: the legacy 16-opcode map sits in the low codes and any wider code is trapped as illegal.

## Interface
- OP_W, 4, opcode width; must be >= 4; codes >= 16 are illegal.
- TIMEOUT, 255, maximum wait cycles in MEM/IO states; 0 disables the timeout.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  when low, the sequencer idles in FETCH and issues no strobes.
- opcode  in  OP_W  instruction opcode, valid while ir_load is high.
- flag_c, flag_z  in  1 each  ALU carry/zero flags.
- mem_ready  in  1  memory completes the current read/write this cycle.
- inp_valid  in  1  input port holds data.
- out_ready  in  1  output port accepts data.
- mem_rd, mem_wr  out  1 each  memory strobes.
- addr_sel  out  1  0 = address from PC, 1 = address from operand.
- ir_load, pc_inc, pc_load  out  1 each  IR/PC controls.
- acc_load, imm_sel, alu_en, flags_load  out  1 each  datapath controls.
- inp_ack, out_valid  out  1 each  I/O handshake.
- busy  out  1  high in any state other than FETCH.
- err_timeout, err_illegal  out  1 each  sticky error flags; cleared only by rst.
- state  out  3  current state encoding, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, IO=4. Encodings 5-7 are unreachable and go to FETCH.
- **FETCH** (run=1):
  - Assert mem_rd with addr_sel=0.
  - When mem_ready=1: pulse ir_load and pc_inc, then go to DECODE.
  - Never times out; waits indefinitely.
  - With run=0, all strobes are low.
- **DECODE**:
  - Register the class from opcode (one of IMM, ALU, JMP, MR, MW, INP, OUT, ILL) and the low 4 opcode bits, then go to EXEC.
  - Class map: 0 → MR; 1 → IMM; 2 → MW; 3 → INP; 4 → OUT; 5-7 → JMP; 8-15 → ALU; >= 16 → ILL.
- **EXEC**:
  - IMM: acc_load=1, imm_sel=1, then FETCH.
  - ALU: alu_en=1, acc_load=1, flags_load=1, with imm_sel=1 only for opcode 8 (ADI); then FETCH.
  - JMP: pc_load=1 if (5 and flag_c) or (6 and flag_z) or 7; then FETCH. A branch that is not taken asserts no strobes.
  - MR, MW: go to MEM. INP, OUT: go to IO.
  - ILL: set err_illegal, assert no strobes, then FETCH (behaves as a NOP).
- **MEM**:
  - Assert addr_sel=1, plus mem_rd (MR) or mem_wr (MW), every cycle.
  - When mem_ready=1: for MR, acc_load=1 in the same cycle; then FETCH.
- **IO**:
  - INP: when inp_valid=1, assert inp_ack=1 and acc_load=1 in that cycle, then FETCH.
  - OUT: assert out_valid=1 until out_ready=1; the cycle where both are high completes the transfer, then FETCH.
- **Timeout**:
  - The wait counter is $clog2(TIMEOUT+1) bits. It clears on entry to MEM/IO and increments each cycle the handshake is not met.
  - At count == TIMEOUT with no handshake: set err_timeout, suppress acc_load, go to FETCH.
  - A handshake arriving in the expiry cycle wins and completes normally.
- All strobes are combinational from state, registered class, flags and handshake inputs. Only state, class, counter and error flags are registers.

## Timing
- Reset values:
  - state=FETCH, class=ILL-free zero (MR), counter=0, err_*=0.
  - All strobes are 0 during reset.
  - After release, mem_rd=run in FETCH.
- Reset mid-instruction abandons the instruction immediately, with no completion strobe.
- Minimum latency with zero-wait memory:
  - IMM, ALU, JMP, ILL: 3 cycles.
  - MR, MW, INP, OUT: 4 cycles.
- Each wait cycle in FETCH, MEM or IO adds 1 cycle.
- flag_c/flag_z are sampled in the EXEC cycle.
- run is sampled only in FETCH. Deasserting run mid-instruction lets the instruction finish.
- pc_inc and ir_load are asserted for exactly one cycle per fetch. pc_load is asserted for at most one cycle per instruction.

## Test plan
- Reset, then LDI (opcode 1) with mem_ready tied high -> ir_load/pc_inc at cycle 0, imm_sel+acc_load at cycle 2, FETCH again at cycle 3.
- BRZ (6) with flag_z=0, then again with flag_z=1 -> no pc_load on the first; pc_load for one cycle in EXEC on the second. JMP (7) -> pc_load regardless of flags.
- LDA (0) with mem_ready low for 5 MEM cycles, then high -> mem_rd+addr_sel=1 for 6 cycles, acc_load in the 6th, err_timeout=0.
- OUT (4), TIMEOUT=3, out_ready held low -> out_valid for 4 cycles, err_timeout set, FETCH next, no acc_load. A second OUT with out_ready high completes in 4 cycles with err_timeout still 1.
- OP_W=5, opcode 5'h13 -> err_illegal=1, no datapath strobes, next fetch proceeds normally.
- rst asserted in MEM state mid-wait -> outputs immediately 0, state=0; run=0 after release keeps mem_rd low.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// Memory and I/O handshake bundle between the control sequencer (master) and the bus side (slave).
// mem_rd/mem_wr hold until mem_ready; inp_ack answers inp_valid in the same cycle;
// out_valid holds until out_ready, and the cycle with both high transfers the data.
interface ctrl_sequencer_if;
  logic mem_rd;
  logic mem_wr;
  logic addr_sel;
  logic mem_ready;
  logic inp_valid;
  logic inp_ack;
  logic out_valid;
  logic out_ready;

  modport master (
    output mem_rd, mem_wr, addr_sel, inp_ack, out_valid,
    input  mem_ready, inp_valid, out_ready
  );

  modport slave (
    input  mem_rd, mem_wr, addr_sel, inp_ack, out_valid,
    output mem_ready, inp_valid, out_ready
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Registered FETCH/DECODE/EXEC control sequencer for the accumulator CPU, with
// memory/I/O handshakes, flag-based branches, wait timeout and illegal-opcode trap.
module ctrl_sequencer #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  ctrl_sequencer_if.master bus,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic             imm_sel,
  output logic             alu_en,
  output logic             flags_load,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [2:0]       state
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_IO     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_MR, C_IMM, C_MW, C_INP, C_OUT, C_JMP, C_ALU, C_ILL
  } class_t;

  state_t           state_q, state_d;
  class_t           cls_q, cls_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_to_q, err_il_q;
  logic             set_to, set_il;
  logic             expire, io_done;
  logic             mem_rd, mem_wr, addr_sel, inp_ack, out_valid;

  function automatic class_t decode_class(input logic [OP_W-1:0] op);
    if (32'(op) >= 32'd16) return C_ILL;
    case (op[3:0])
      4'd0:                 return C_MR;
      4'd1:                 return C_IMM;
      4'd2:                 return C_MW;
      4'd3:                 return C_INP;
      4'd4:                 return C_OUT;
      4'd5, 4'd6, 4'd7:     return C_JMP;
      default:              return C_ALU;
    endcase
  endfunction

  // A TIMEOUT of zero leaves the counter running but never expiring.
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      cls_q    <= C_MR;
      op_q     <= 4'd0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      if (set_to) err_to_q <= 1'b1;
      if (set_il) err_il_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    set_to     = 1'b0;
    set_il     = 1'b0;
    io_done    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    inp_ack    = 1'b0;
    out_valid  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    imm_sel    = 1'b0;
    alu_en     = 1'b0;
    flags_load = 1'b0;
    // Strobes stay low for as long as reset is held, even though state reads FETCH.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_rd = 1'b1;
            if (bus.mem_ready) begin
              ir_load = 1'b1;
              pc_inc  = 1'b1;
              state_d = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          cls_d   = decode_class(opcode);
          op_d    = opcode[3:0];
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          cnt_d   = '0;
          case (cls_q)
            C_IMM: begin
              acc_load = 1'b1;
              imm_sel  = 1'b1;
            end
            C_ALU: begin
              alu_en     = 1'b1;
              acc_load   = 1'b1;
              flags_load = 1'b1;
              imm_sel    = (op_q == 4'd8);
            end
            C_JMP: pc_load = ((op_q == 4'd5) && flag_c) || ((op_q == 4'd6) && flag_z) ||
                             (op_q == 4'd7);
            C_MR, C_MW:   state_d = S_MEM;
            C_INP, C_OUT: state_d = S_IO;
            default:      set_il = 1'b1;
          endcase
        end
        S_MEM: begin
          addr_sel = 1'b1;
          mem_rd   = (cls_q == C_MR);
          mem_wr   = (cls_q == C_MW);
          if (bus.mem_ready) begin
            acc_load = (cls_q == C_MR);
            state_d  = S_FETCH;
          end else if (expire) begin
            set_to  = 1'b1;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_IO: begin
          if (cls_q == C_INP) begin
            io_done  = bus.inp_valid;
            inp_ack  = bus.inp_valid;
            acc_load = bus.inp_valid;
          end else begin
            out_valid = 1'b1;
            io_done   = bus.out_ready;
          end
          if (io_done) begin
            state_d = S_FETCH;
          end else if (expire) begin
            set_to  = 1'b1;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.addr_sel  = addr_sel;
  assign bus.inp_ack   = inp_ack;
  assign bus.out_valid = out_valid;
  assign busy          = (state_q != S_FETCH);
  assign err_timeout   = err_to_q;
  assign err_illegal   = err_il_q;
  assign state         = state_q;
endmodule
